// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control path.
//   - opcode / funct field constants
//   - ula32 operation codes driven on ula_selector
//   - select encodings for mux1..mux5 and mux13
//   - main controller state enum
//   - funct_can_overflow(): true for the R-type ops whose overflow traps
package cpu_ctrl_pkg;

    // IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // IR[5:0] for R-type
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    // ula32 operations
    localparam logic [2:0] ULA_LOAD = 3'b000;
    localparam logic [2:0] ULA_ADD  = 3'b001;
    localparam logic [2:0] ULA_SUB  = 3'b010;
    localparam logic [2:0] ULA_AND  = 3'b011;
    localparam logic [2:0] ULA_CMP  = 3'b111;

    // mux1: memory address
    localparam logic [2:0] M1_PC     = 3'd0;
    localparam logic [2:0] M1_ALUOUT = 3'd1;
    // mux2: register destination
    localparam logic [2:0] M2_RT = 3'd1;
    localparam logic [2:0] M2_RD = 3'd2;
    // mux3: register write data
    localparam logic [2:0] M3_MEM    = 3'd0;
    localparam logic [2:0] M3_ALUOUT = 3'd1;
    // mux4: ALU A operand
    localparam logic [2:0] M4_PC = 3'd0;
    localparam logic [2:0] M4_A  = 3'd1;
    // mux5: ALU B operand
    localparam logic [2:0] M5_B       = 3'd0;
    localparam logic [2:0] M5_IMM     = 3'd1;
    localparam logic [2:0] M5_IMM_SH2 = 3'd2;
    localparam logic [2:0] M5_FOUR    = 3'd3;
    // mux13: PC source
    localparam logic [2:0] M13_ALU    = 3'd0;
    localparam logic [2:0] M13_ALUOUT = 3'd1;
    localparam logic [2:0] M13_JUMP   = 3'd2;
    localparam logic [2:0] M13_EXC    = 3'd3;

    typedef enum logic [4:0] {
        S_RST,
        S_F0,
        S_F1,
        S_F2,
        S_DEC,
        S_EXR,
        S_WBR,
        S_EXI,
        S_WBI,
        S_ADR,
        S_RD0,
        S_RD1,
        S_LWB,
        S_SW,
        S_BR,
        S_J,
        S_EXC
    } state_t;

    // Only add and sub raise an overflow exception; and never does.
    function automatic logic funct_can_overflow(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB);
    endfunction

endpackage

// File: rtl/alu_funct_decode.sv
// R-type funct decoder.
//   funct  in  6  IR[5:0]
//   ula_op out 3  ula32 operation for the funct (ULA_LOAD when undefined)
//   valid  out 1  funct is one of add/sub/and
module alu_funct_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] ula_op,
    output logic       valid
);

    always_comb begin
        ula_op = ULA_LOAD;
        valid  = 1'b0;
        case (funct)
            FN_ADD: begin
                ula_op = ULA_ADD;
                valid  = 1'b1;
            end
            FN_SUB: begin
                ula_op = ULA_SUB;
                valid  = 1'b1;
            end
            FN_AND: begin
                ula_op = ULA_AND;
                valid  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS-subset datapath.
// Sequences fetch, decode, execute, memory and writeback; outputs are decoded
// from state, except PC_w in BR (qualified by Igual), ALUOut_w in EXR
// (qualified by a valid funct) and the reset gating of every write enable.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   opcode, funct                     IR[31:26], IR[5:0]
//   Overflow, Igual                   ula32 flags used in EXR/EXI/BR
//   Zero, Negativo, Maior, Menor      ula32 flags, not used
//   PC_w .. epc_w                     datapath write enables
//   ula_selector                      ALU operation
//   mux1_s..mux5_s, mux13_s           datapath mux selects
//   rst_out                           register-file reset strobe (state RST)
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Overflow,
    input  logic       Igual,
    input  logic       Zero,
    input  logic       Negativo,
    input  logic       Maior,
    input  logic       Menor,
    output logic       PC_w,
    output logic       memoria_w,
    output logic       IR_control,
    output logic       a_w,
    output logic       b_w,
    output logic       reg_w,
    output logic       ALUOut_w,
    output logic       epc_w,
    output logic [2:0] ula_selector,
    output logic [2:0] mux1_s,
    output logic [2:0] mux2_s,
    output logic [2:0] mux3_s,
    output logic [2:0] mux4_s,
    output logic [2:0] mux5_s,
    output logic [2:0] mux13_s,
    output logic       rst_out
);

    localparam int WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
    // With no wait cycles the F1/RD1 states are skipped entirely.
    localparam state_t AFTER_F0  = (MEM_WAIT > 0) ? S_F1  : S_F2;
    localparam state_t AFTER_RD0 = (MEM_WAIT > 0) ? S_RD1 : S_LWB;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_last;
    logic [2:0]        funct_ula;
    logic              funct_valid;

    logic unused_flags;
    assign unused_flags = ^{Zero, Negativo, Maior, Menor};

    alu_funct_decode u_funct_decode (
        .funct  (funct),
        .ula_op (funct_ula),
        .valid  (funct_valid)
    );

    assign wait_last = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RST;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            // Counts cycles spent in a memory wait state; cleared elsewhere.
            if ((state == S_F1 || state == S_RD1) && !wait_last)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        state_next   = state;
        PC_w         = 1'b0;
        memoria_w    = 1'b0;
        IR_control   = 1'b0;
        a_w          = 1'b0;
        b_w          = 1'b0;
        reg_w        = 1'b0;
        ALUOut_w     = 1'b0;
        epc_w        = 1'b0;
        rst_out      = 1'b0;
        ula_selector = ULA_LOAD;
        mux1_s       = M1_PC;
        mux2_s       = 3'd0;
        mux3_s       = M3_MEM;
        mux4_s       = M4_PC;
        mux5_s       = M5_B;
        mux13_s      = M13_ALU;

        case (state)
            S_RST: begin
                rst_out    = 1'b1;
                state_next = S_F0;
            end
            S_F0: begin
                state_next = AFTER_F0;
            end
            S_F1: begin
                if (wait_last)
                    state_next = S_F2;
            end
            S_F2: begin
                IR_control   = 1'b1;
                mux5_s       = M5_FOUR;
                ula_selector = ULA_ADD;
                PC_w         = 1'b1;
                state_next   = S_DEC;
            end
            S_DEC: begin
                // A/B latch the register operands while ALUOut gets the
                // branch target, in case this turns out to be a branch.
                a_w          = 1'b1;
                b_w          = 1'b1;
                mux5_s       = M5_IMM_SH2;
                ula_selector = ULA_ADD;
                ALUOut_w     = 1'b1;
                case (opcode)
                    OP_RTYPE:     state_next = S_EXR;
                    OP_ADDI:      state_next = S_EXI;
                    OP_LW, OP_SW: state_next = S_ADR;
                    OP_BEQ, OP_BNE: state_next = S_BR;
                    OP_J:         state_next = S_J;
                    default:      state_next = S_EXC;
                endcase
            end
            S_EXR: begin
                mux4_s       = M4_A;
                ula_selector = funct_ula;
                ALUOut_w     = funct_valid;
                if (!funct_valid)
                    state_next = S_EXC;
                else if (Overflow && funct_can_overflow(funct))
                    state_next = S_EXC;
                else
                    state_next = S_WBR;
            end
            S_WBR: begin
                reg_w      = 1'b1;
                mux2_s     = M2_RD;
                mux3_s     = M3_ALUOUT;
                state_next = S_F0;
            end
            S_EXI: begin
                mux4_s       = M4_A;
                mux5_s       = M5_IMM;
                ula_selector = ULA_ADD;
                ALUOut_w     = 1'b1;
                state_next   = Overflow ? S_EXC : S_WBI;
            end
            S_WBI: begin
                reg_w      = 1'b1;
                mux2_s     = M2_RT;
                mux3_s     = M3_ALUOUT;
                state_next = S_F0;
            end
            S_ADR: begin
                mux4_s       = M4_A;
                mux5_s       = M5_IMM;
                ula_selector = ULA_ADD;
                ALUOut_w     = 1'b1;
                // Only lw and sw reach ADR.
                state_next   = (opcode == OP_LW) ? S_RD0 : S_SW;
            end
            S_RD0: begin
                mux1_s     = M1_ALUOUT;
                state_next = AFTER_RD0;
            end
            S_RD1: begin
                mux1_s = M1_ALUOUT;
                if (wait_last)
                    state_next = S_LWB;
            end
            S_LWB: begin
                mux1_s     = M1_ALUOUT;
                reg_w      = 1'b1;
                mux2_s     = M2_RT;
                mux3_s     = M3_MEM;
                state_next = S_F0;
            end
            S_SW: begin
                mux1_s     = M1_ALUOUT;
                memoria_w  = 1'b1;
                state_next = S_F0;
            end
            S_BR: begin
                mux4_s       = M4_A;
                ula_selector = ULA_CMP;
                mux13_s      = M13_ALUOUT;
                PC_w         = (opcode == OP_BEQ) ? Igual : ~Igual;
                state_next   = S_F0;
            end
            S_J: begin
                mux13_s    = M13_JUMP;
                PC_w       = 1'b1;
                state_next = S_F0;
            end
            S_EXC: begin
                // PC already holds PC+4, so PC-4 rewinds to the faulting
                // instruction for EPC.
                mux5_s       = M5_FOUR;
                ula_selector = ULA_SUB;
                epc_w        = 1'b1;
                mux13_s      = M13_EXC;
                PC_w         = 1'b1;
                state_next   = S_F0;
            end
            default: begin
                state_next = S_RST;
            end
        endcase

        // Reset must never let a half-finished instruction commit anything.
        if (reset) begin
            PC_w       = 1'b0;
            memoria_w  = 1'b0;
            IR_control = 1'b0;
            a_w        = 1'b0;
            b_w        = 1'b0;
            reg_w      = 1'b0;
            ALUOut_w   = 1'b0;
            epc_w      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table covering every
// instruction class, followed by hand-written reset-during-instruction cases.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_w;
        logic       mem_w;
        logic       ir_c;
        logic       a_w;
        logic       b_w;
        logic       reg_w;
        logic       aluout_w;
        logic       epc_w;
        logic       rst_out;
        logic [2:0] ula;
        logic [2:0] m1;
        logic [2:0] m2;
        logic [2:0] m3;
        logic [2:0] m4;
        logic [2:0] m5;
        logic [2:0] m13;
    } ctrl_t;

    typedef struct {
        bit         rst;
        logic [5:0] op;
        logic [5:0] fn;
        bit         ov;
        bit         eq;
        ctrl_t      exp;
        bit         ula_x;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       Overflow = 1'b0;
    logic       Igual = 1'b0;
    logic       Zero = 1'b0;
    logic       Negativo = 1'b0;
    logic       Maior = 1'b0;
    logic       Menor = 1'b0;

    logic       PC_w, memoria_w, IR_control, a_w, b_w, reg_w, ALUOut_w, epc_w, rst_out;
    logic [2:0] ula_selector, mux1_s, mux2_s, mux3_s, mux4_s, mux5_s, mux13_s;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t  vecs[$];
    ctrl_t got;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_WAIT(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .Overflow     (Overflow),
        .Igual        (Igual),
        .Zero         (Zero),
        .Negativo     (Negativo),
        .Maior        (Maior),
        .Menor        (Menor),
        .PC_w         (PC_w),
        .memoria_w    (memoria_w),
        .IR_control   (IR_control),
        .a_w          (a_w),
        .b_w          (b_w),
        .reg_w        (reg_w),
        .ALUOut_w     (ALUOut_w),
        .epc_w        (epc_w),
        .ula_selector (ula_selector),
        .mux1_s       (mux1_s),
        .mux2_s       (mux2_s),
        .mux3_s       (mux3_s),
        .mux4_s       (mux4_s),
        .mux5_s       (mux5_s),
        .mux13_s      (mux13_s),
        .rst_out      (rst_out)
    );

    assign got = '{pc_w: PC_w, mem_w: memoria_w, ir_c: IR_control, a_w: a_w, b_w: b_w,
                   reg_w: reg_w, aluout_w: ALUOut_w, epc_w: epc_w, rst_out: rst_out,
                   ula: ula_selector, m1: mux1_s, m2: mux2_s, m3: mux3_s, m4: mux4_s,
                   m5: mux5_s, m13: mux13_s};

    // en = {pc_w, mem_w, ir_c, a_w, b_w, reg_w, aluout_w, epc_w, rst_out}
    function automatic ctrl_t mk(input logic [8:0] en, input logic [2:0] ula,
                                 input logic [2:0] m1, input logic [2:0] m2,
                                 input logic [2:0] m3, input logic [2:0] m4,
                                 input logic [2:0] m5, input logic [2:0] m13);
        ctrl_t c;
        {c.pc_w, c.mem_w, c.ir_c, c.a_w, c.b_w, c.reg_w, c.aluout_w, c.epc_w, c.rst_out} = en;
        c.ula = ula; c.m1 = m1; c.m2 = m2; c.m3 = m3; c.m4 = m4; c.m5 = m5; c.m13 = m13;
        return c;
    endfunction

    ctrl_t C_RST, C_F0, C_F2, C_F2_GATED, C_DEC, C_EXR_ADD, C_EXR_SUB, C_EXR_AND, C_EXR_BAD;
    ctrl_t C_WBR, C_EXI, C_WBI, C_RD, C_LWB, C_SW, C_BR_T, C_BR_N, C_J, C_EXC;

    task automatic add(input bit r, input logic [5:0] op, input logic [5:0] fn,
                       input bit ov, input bit eq, input ctrl_t e, input bit ux = 1'b0);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.ov = ov; v.eq = eq; v.exp = e; v.ula_x = ux;
        vecs.push_back(v);
    endtask

    // F0, F1, F2, DEC rows of one instruction.
    task automatic add_fetch(input logic [5:0] op, input logic [5:0] fn, input bit dec_ov);
        add(1'b0, op, fn, 1'b0, 1'b0, C_F0);
        add(1'b0, op, fn, 1'b0, 1'b0, C_F0);
        add(1'b0, op, fn, 1'b0, 1'b0, C_F2);
        add(1'b0, op, fn, dec_ov, 1'b0, C_DEC);
    endtask

    task automatic drive(input bit r, input logic [5:0] op, input logic [5:0] fn,
                         input bit ov, input bit eq);
        @(negedge clk);
        reset = r; opcode = op; funct = fn; Overflow = ov; Igual = eq;
        #1;
    endtask

    task automatic check(input string nm, input ctrl_t exp, input bit ux);
        ctrl_t g, e;
        g = got;
        e = exp;
        if (ux) begin
            g.ula = 3'b000;
            e.ula = 3'b000;
        end
        n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, g, e);
        end
    endtask

    task automatic step(input string nm, input bit r, input logic [5:0] op, input ctrl_t e);
        drive(r, op, 6'h00, 1'b0, 1'b0);
        check(nm, e, 1'b0);
    endtask

    initial begin
        C_RST      = mk(9'b000000001, 3'b000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        C_F0       = mk(9'b000000000, 3'b000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        C_F2       = mk(9'b101000000, 3'b001, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0);
        C_F2_GATED = mk(9'b000000000, 3'b001, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0);
        C_DEC      = mk(9'b000110100, 3'b001, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0);
        C_EXR_ADD  = mk(9'b000000100, 3'b001, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0);
        C_EXR_SUB  = mk(9'b000000100, 3'b010, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0);
        C_EXR_AND  = mk(9'b000000100, 3'b011, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0);
        C_EXR_BAD  = mk(9'b000000000, 3'b000, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0);
        C_WBR      = mk(9'b000001000, 3'b000, 3'd0, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0);
        C_EXI      = mk(9'b000000100, 3'b001, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0);
        C_WBI      = mk(9'b000001000, 3'b000, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0);
        C_RD       = mk(9'b000000000, 3'b000, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        C_LWB      = mk(9'b000001000, 3'b000, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0);
        C_SW       = mk(9'b010000000, 3'b000, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        C_BR_T     = mk(9'b100000000, 3'b111, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1);
        C_BR_N     = mk(9'b000000000, 3'b111, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1);
        C_J        = mk(9'b100000000, 3'b000, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2);
        C_EXC      = mk(9'b100000010, 3'b010, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3);

        // Reset: RST while held, RST for one cycle after release.
        add(1'b1, 6'h00, 6'h00, 1'b0, 1'b0, C_RST);
        add(1'b0, 6'h00, 6'h00, 1'b0, 1'b0, C_RST);
        // add, no overflow
        add_fetch(6'h00, 6'h20, 1'b0);
        add(1'b0, 6'h00, 6'h20, 1'b0, 1'b0, C_EXR_ADD);
        add(1'b0, 6'h00, 6'h20, 1'b0, 1'b0, C_WBR);
        // sub with overflow traps
        add_fetch(6'h00, 6'h22, 1'b0);
        add(1'b0, 6'h00, 6'h22, 1'b1, 1'b0, C_EXR_SUB);
        add(1'b0, 6'h00, 6'h22, 1'b0, 1'b0, C_EXC);
        // and ignores overflow
        add_fetch(6'h00, 6'h24, 1'b0);
        add(1'b0, 6'h00, 6'h24, 1'b1, 1'b0, C_EXR_AND);
        add(1'b0, 6'h00, 6'h24, 1'b0, 1'b0, C_WBR);
        // addi: overflow in DEC is ignored, none in EXI
        add_fetch(6'h08, 6'h00, 1'b1);
        add(1'b0, 6'h08, 6'h00, 1'b0, 1'b0, C_EXI);
        add(1'b0, 6'h08, 6'h00, 1'b0, 1'b0, C_WBI);
        // addi with overflow
        add_fetch(6'h08, 6'h00, 1'b0);
        add(1'b0, 6'h08, 6'h00, 1'b1, 1'b0, C_EXI);
        add(1'b0, 6'h08, 6'h00, 1'b0, 1'b0, C_EXC);
        // beq taken / not taken, bne taken / not taken
        add_fetch(6'h04, 6'h00, 1'b0);
        add(1'b0, 6'h04, 6'h00, 1'b0, 1'b1, C_BR_T);
        add_fetch(6'h04, 6'h00, 1'b0);
        add(1'b0, 6'h04, 6'h00, 1'b0, 1'b0, C_BR_N);
        add_fetch(6'h05, 6'h00, 1'b0);
        add(1'b0, 6'h05, 6'h00, 1'b0, 1'b0, C_BR_T);
        add_fetch(6'h05, 6'h00, 1'b0);
        add(1'b0, 6'h05, 6'h00, 1'b0, 1'b1, C_BR_N);
        // j
        add_fetch(6'h02, 6'h00, 1'b0);
        add(1'b0, 6'h02, 6'h00, 1'b0, 1'b0, C_J);
        // sw
        add_fetch(6'h2B, 6'h00, 1'b0);
        add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, C_EXI);
        add(1'b0, 6'h2B, 6'h00, 1'b0, 1'b0, C_SW);
        // lw: ADR, RD0, RD1, LWB
        add_fetch(6'h23, 6'h00, 1'b0);
        add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, C_EXI);
        add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, C_RD);
        add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, C_RD);
        add(1'b0, 6'h23, 6'h00, 1'b0, 1'b0, C_LWB);
        // undefined opcode
        add_fetch(6'h3F, 6'h00, 1'b0);
        add(1'b0, 6'h3F, 6'h00, 1'b0, 1'b0, C_EXC);
        // undefined funct (ALU op in EXR left unchecked)
        add_fetch(6'h00, 6'h2A, 1'b0);
        add(1'b0, 6'h00, 6'h2A, 1'b0, 1'b0, C_EXR_BAD, 1'b1);
        add(1'b0, 6'h00, 6'h2A, 1'b0, 1'b0, C_EXC);

        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].ov, vecs[i].eq);
            check($sformatf("vec[%0d]", i), vecs[i].exp, vecs[i].ula_x);
        end

        // Reset held two cycles while lw sits in RD1.
        step("lw_f0",  1'b0, 6'h23, C_F0);
        step("lw_f1",  1'b0, 6'h23, C_F0);
        step("lw_f2",  1'b0, 6'h23, C_F2);
        step("lw_dec", 1'b0, 6'h23, C_DEC);
        step("lw_adr", 1'b0, 6'h23, C_EXI);
        step("lw_rd0", 1'b0, 6'h23, C_RD);
        step("lw_rd1_rst", 1'b1, 6'h23, C_RD);
        step("rst_held",   1'b1, 6'h23, C_RST);
        step("rst_release", 1'b0, 6'h23, C_RST);
        step("restart_f0", 1'b0, 6'h23, C_F0);
        step("restart_f1", 1'b0, 6'h23, C_F0);
        // Reset arriving in F2 must suppress PC_w and IR_control at once.
        step("f2_rst_gated", 1'b1, 6'h23, C_F2_GATED);
        step("rst_after_f2", 1'b0, 6'h23, C_RST);
        step("again_f0", 1'b0, 6'h00, C_F0);
        step("again_f1", 1'b0, 6'h00, C_F0);
        step("again_f2", 1'b0, 6'h00, C_F2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
